// File: rtl/calc_pkg.sv
// Shared types and key codes for the calculator keypad entry controller.
package calc_pkg;

  // Controller states; the encoding is also what drives the state LEDs.
  typedef enum logic [2:0] {
    ST_ENTER_A  = 3'd0,
    ST_ENTER_OP = 3'd1,
    ST_ENTER_B  = 3'd2,
    ST_CALC     = 3'd3,
    ST_SHOW     = 3'd4
  } state_e;

  // ALU operation select, in the same order as the operator keys.
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  // Non-digit key codes; 0x00-0x0F are hex digits, 0x16-0x1F are reserved.
  localparam logic [4:0] KEY_ENTER = 5'h10;
  localparam logic [4:0] KEY_CLEAR = 5'h11;
  localparam logic [4:0] KEY_ADD   = 5'h12;
  localparam logic [4:0] KEY_SUB   = 5'h13;
  localparam logic [4:0] KEY_AND   = 5'h14;
  localparam logic [4:0] KEY_OR    = 5'h15;

endpackage

// File: rtl/calc_entry_ctrl.sv
// Keypad entry sequencer for a two-operand hex calculator.
// Steers digit keys into the operand shift registers, latches the operator,
// starts the ALU and selects the result for display. Every output is
// registered, so a key seen in one cycle is reflected in the next.
//
//   state       | meaning
//   ------------+------------------------------------------------
//   ST_ENTER_A  | collecting digits of operand A
//   ST_ENTER_OP | operand A closed, waiting for an operator key
//   ST_ENTER_B  | collecting digits of operand B
//   ST_CALC     | ALU started, waiting for alu_done
//   ST_SHOW     | result displayed, next key restarts entry
module calc_entry_ctrl
  import calc_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [4:0] key_code,
  input  logic       alu_done,
  output logic       shift_a,
  output logic       shift_b,
  output logic       clear_a,
  output logic       clear_b,
  output logic [4:0] digit_out,
  output logic [1:0] op_code,
  output logic       alu_start,
  output logic       show_result,
  output logic [2:0] state_out,
  output logic       digits_full
);

  localparam int            CW      = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIGITS);

  state_e        state_q;
  op_e           op_q;
  logic [CW-1:0] cnt_q;
  logic [4:0]    digit_q;
  logic          shift_a_q, shift_b_q, clear_q, alu_start_q;
  logic          show_q, full_q;

  logic          is_digit, is_enter, is_clear, is_op, is_known;
  logic          cnt_room;
  logic [CW-1:0] cnt_inc;

  // Key classification; reserved codes match none of these.
  assign is_digit = key_valid && (key_code[4] == 1'b0);
  assign is_enter = key_valid && (key_code == KEY_ENTER);
  assign is_clear = key_valid && (key_code == KEY_CLEAR);
  assign is_op    = key_valid && (key_code >= KEY_ADD) && (key_code <= KEY_OR);
  assign is_known = key_valid && (key_code <= KEY_OR);

  // Counter saturates at DIGITS: further digits are simply not accepted.
  assign cnt_room = (cnt_q < CNT_MAX);
  assign cnt_inc  = cnt_q + 1'b1;

  // Sequencer with registered outputs; pulse outputs default low each cycle.
  always_ff @(posedge clk) begin
    shift_a_q   <= 1'b0;
    shift_b_q   <= 1'b0;
    clear_q     <= 1'b0;
    alu_start_q <= 1'b0;
    if (rst) begin
      state_q <= ST_ENTER_A;
      cnt_q   <= '0;
      op_q    <= OP_ADD;
      digit_q <= '0;
      full_q  <= 1'b0;
      show_q  <= 1'b0;
    end else if (is_clear) begin
      // CLEAR beats everything, including a simultaneous alu_done in CALC.
      clear_q <= 1'b1;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      show_q  <= 1'b0;
      state_q <= ST_ENTER_A;
    end else begin
      case (state_q)
        ST_ENTER_A, ST_ENTER_B: begin
          if (is_digit && cnt_room) begin
            shift_a_q <= (state_q == ST_ENTER_A);
            shift_b_q <= (state_q == ST_ENTER_B);
            digit_q   <= {1'b0, key_code[3:0]};
            cnt_q     <= cnt_inc;
            full_q    <= (cnt_inc == CNT_MAX);
          end else if (is_enter && (cnt_q != '0)) begin
            if (state_q == ST_ENTER_A) begin
              state_q <= ST_ENTER_OP;
            end else begin
              state_q     <= ST_CALC;
              alu_start_q <= 1'b1;
            end
          end
        end
        ST_ENTER_OP: begin
          if (is_op) begin
            // 0x12..0x15 map to 0..3; the low two bits minus 2 give that.
            op_q    <= op_e'(key_code[1:0] - 2'd2);
            cnt_q   <= '0;
            full_q  <= 1'b0;
            state_q <= ST_ENTER_B;
          end
        end
        ST_CALC: begin
          if (alu_done) begin
            state_q <= ST_SHOW;
            show_q  <= 1'b1;
          end
        end
        ST_SHOW: begin
          // Any non-reserved key is consumed to restart entry.
          if (is_known) begin
            clear_q <= 1'b1;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            show_q  <= 1'b0;
            state_q <= ST_ENTER_A;
          end
        end
        default: state_q <= ST_ENTER_A;
      endcase
    end
  end

  assign shift_a     = shift_a_q;
  assign shift_b     = shift_b_q;
  assign clear_a     = clear_q;
  assign clear_b     = clear_q;
  assign digit_out   = digit_q;
  assign op_code     = op_q;
  assign alu_start   = alu_start_q;
  assign show_result = show_q;
  assign state_out   = state_q;
  assign digits_full = full_q;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Bench for calc_entry_ctrl: directed scenarios followed by random key and
// alu_done traffic, all compared cycle by cycle against a queue-based model
// of the calculator entry rules.
module tb_calc_entry_ctrl;
  import calc_pkg::*;

  localparam int DIGITS = 4;

  logic       clk = 1'b0;
  logic       rst, key_valid, alu_done;
  logic [4:0] key_code;
  logic       shift_a, shift_b, clear_a, clear_b, alu_start, show_result, digits_full;
  logic [4:0] digit_out;
  logic [1:0] op_code;
  logic [2:0] state_out;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: operands are queues of the digits actually accepted.
  state_e     m_st;
  logic [3:0] qa[$];
  logic [3:0] qb[$];
  logic [1:0] m_op;
  logic [4:0] m_dout;
  logic       m_sa, m_sb, m_clr, m_start;

  always #5 clk = ~clk;

  calc_entry_ctrl #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .alu_done(alu_done), .shift_a(shift_a), .shift_b(shift_b),
    .clear_a(clear_a), .clear_b(clear_b), .digit_out(digit_out),
    .op_code(op_code), .alu_start(alu_start), .show_result(show_result),
    .state_out(state_out), .digits_full(digits_full)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, input logic kv, input logic [4:0] kc, input logic ad);
    bit dig, ent;
    dig = kv && (kc < 5'h10);
    ent = kv && (kc == KEY_ENTER);
    m_sa = 0; m_sb = 0; m_clr = 0; m_start = 0;
    if (r) begin
      m_st = ST_ENTER_A; qa.delete(); qb.delete(); m_op = 2'd0; m_dout = 5'd0;
    end else if (kv && kc == KEY_CLEAR) begin
      m_clr = 1; qa.delete(); qb.delete(); m_st = ST_ENTER_A;
    end else begin
      case (m_st)
        ST_ENTER_A:
          if (dig) begin
            if (qa.size() < DIGITS) begin
              qa.push_back(kc[3:0]); m_sa = 1; m_dout = {1'b0, kc[3:0]};
            end
          end else if (ent && qa.size() > 0) m_st = ST_ENTER_OP;
        ST_ENTER_OP:
          if (kv && kc >= KEY_ADD && kc <= KEY_OR) begin
            m_op = 2'(kc - KEY_ADD); qb.delete(); m_st = ST_ENTER_B;
          end
        ST_ENTER_B:
          if (dig) begin
            if (qb.size() < DIGITS) begin
              qb.push_back(kc[3:0]); m_sb = 1; m_dout = {1'b0, kc[3:0]};
            end
          end else if (ent && qb.size() > 0) begin
            m_st = ST_CALC; m_start = 1;
          end
        ST_CALC:
          if (ad) m_st = ST_SHOW;
        default:
          if (kv && kc <= KEY_OR) begin
            m_clr = 1; qa.delete(); qb.delete(); m_st = ST_ENTER_A;
          end
      endcase
    end
  endtask

  function automatic logic m_full();
    if (m_st == ST_ENTER_A || m_st == ST_ENTER_OP) return qa.size() == DIGITS;
    return qb.size() == DIGITS;
  endfunction

  task automatic cyc(input logic r, input logic kv, input logic [4:0] kc, input logic ad);
    rst = r; key_valid = kv; key_code = kc; alu_done = ad;
    model(r, kv, kc, ad);
    @(posedge clk);
    #1;
    check("state_out",   {5'd0, state_out},   {5'd0, 3'(m_st)});
    check("shift_a",     {7'd0, shift_a},     {7'd0, m_sa});
    check("shift_b",     {7'd0, shift_b},     {7'd0, m_sb});
    check("clear_a",     {7'd0, clear_a},     {7'd0, m_clr});
    check("clear_b",     {7'd0, clear_b},     {7'd0, m_clr});
    check("alu_start",   {7'd0, alu_start},   {7'd0, m_start});
    check("show_result", {7'd0, show_result}, {7'd0, (m_st == ST_SHOW)});
    check("op_code",     {6'd0, op_code},     {6'd0, m_op});
    check("digit_out",   {3'd0, digit_out},   {3'd0, m_dout});
    check("digits_full", {7'd0, digits_full}, {7'd0, m_full()});
  endtask

  task automatic key(input logic [4:0] kc);
    cyc(1'b0, 1'b1, kc, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 5'h00, 1'b0);
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_code = 5'h00; alu_done = 1'b0;
    // Reset, with junk on the inputs that must be overridden.
    cyc(1'b1, 1'b1, 5'h05, 1'b1);
    cyc(1'b1, 1'b0, 5'h00, 1'b0);

    // Five digits then ENTER: four shifts, fifth ignored, full, ENTER_OP.
    key(5'h1); key(5'h2); key(5'h3); key(5'h4); key(5'h5); key(KEY_ENTER);
    idle(1);

    // A=0xA, SUB, B=0x3, ENTER, alu_done five cycles later, then SHOW.
    key(KEY_CLEAR);
    key(5'hA); key(KEY_ENTER); key(KEY_SUB); key(5'h3); key(KEY_ENTER);
    idle(4);
    cyc(1'b0, 1'b0, 5'h00, 1'b1);
    idle(2);

    // Digit key in SHOW: clears and restarts without a shift.
    key(5'h7);
    idle(2);

    // ENTER with empty operands in ENTER_A and ENTER_B.
    key(KEY_ENTER); key(5'hC); key(KEY_ENTER); key(KEY_ADD); key(KEY_ENTER);
    // Operator and reserved keys ignored in ENTER_B; alu_done ignored too.
    key(KEY_OR); key(5'h1F); cyc(1'b0, 1'b0, 5'h00, 1'b1);
    key(5'h2); key(KEY_ENTER);
    // CLEAR in CALC, then a late alu_done must not reach SHOW.
    key(KEY_CLEAR);
    cyc(1'b0, 1'b0, 5'h00, 1'b1);
    idle(2);

    // Key and alu_done together in CALC: alu_done wins, key dropped.
    key(5'h9); key(KEY_ENTER); key(KEY_AND); key(5'h4); key(KEY_ENTER);
    cyc(1'b0, 1'b1, 5'h6, 1'b1);
    // CLEAR and alu_done together: CLEAR wins.
    key(5'h1); key(5'h8); key(KEY_ENTER); key(KEY_OR); key(5'h1); key(KEY_ENTER);
    cyc(1'b0, 1'b1, KEY_CLEAR, 1'b1);

    // rst in ENTER_B with two digits entered.
    key(5'h3); key(KEY_ENTER); key(KEY_OR); key(5'hE); key(5'hF);
    cyc(1'b1, 1'b1, 5'h2, 1'b0);
    idle(1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      int sel;
      logic [4:0] kc;
      sel = $urandom_range(0, 99);
      if (sel < 55)      kc = 5'($urandom_range(0, 15));
      else if (sel < 70) kc = KEY_ENTER;
      else if (sel < 85) kc = 5'($urandom_range(18, 21));
      else if (sel < 88) kc = KEY_CLEAR;
      else               kc = 5'($urandom_range(22, 31));
      cyc(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)), kc,
          ($urandom_range(0, 4) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_entry_ctrl.md
CALC_ENTRY_CTRL -- requirements
Module: calc_entry_ctrl

Interface
REQ-001 Parameter DIGITS, default 4, gives the maximum hex digits per operand; 4 fills a 16-bit operand register.
REQ-002 Signal list (name, direction, width, meaning), one per line:
  clk  in  1  system clock
  rst  in  1  reset; synchronous, active-high
  key_valid  in  1  one-cycle pulse; key_code is valid
  key_code  in  5  0x00-0x0F hex digit; 0x10 ENTER; 0x11 CLEAR; 0x12 ADD; 0x13 SUB; 0x14 AND; 0x15 OR; 0x16-0x1F reserved
  alu_done  in  1  one-cycle pulse; ALU result ready
  shift_a  out  1  one-cycle shift-enable to operand-A shift register
  shift_b  out  1  one-cycle shift-enable to operand-B shift register
  clear_a  out  1  one-cycle synchronous clear of operand A
  clear_b  out  1  one-cycle synchronous clear of operand B
  digit_out  out  5  digit to shift in, {1'b0, nibble}
  op_code  out  2  00 ADD, 01 SUB, 10 AND, 11 OR
  alu_start  out  1  one-cycle start pulse to ALU
  show_result  out  1  level; display selects ALU result
  state_out  out  3  current state encoding for LEDs
  digits_full  out  1  level; active operand holds DIGITS digits

Function
REQ-003 The state machine SHALL have states ENTER_A, ENTER_OP, ENTER_B, CALC, SHOW.
REQ-004 All outputs SHALL be registered: a response to a key_valid in cycle N appears in cycle N+1 only.
REQ-005 ENTER_A/ENTER_B, digit key, count<DIGITS: pulse shift_a or shift_b, load digit_out with {0,key_code[3:0]}, increment count.
REQ-006 Digit key with count==DIGITS SHALL be ignored: no shift pulse, count saturates, digits_full stays 1.
REQ-007 ENTER in ENTER_A with count>0 goes to ENTER_OP; with count==0 it is ignored.
REQ-008 ENTER_OP, key 0x12-0x15: latch op_code=key_code-0x12, go to ENTER_B, reset count to 0; other keys except CLEAR are ignored.
REQ-009 ENTER in ENTER_B with count>0 goes to CALC and pulses alu_start for exactly one cycle, on the cycle CALC is entered; with count==0 it is ignored.
REQ-010 CALC: alu_done goes to SHOW; show_result is 1 only in SHOW; keys other than CLEAR are ignored in CALC.
REQ-011 SHOW, any key: pulse clear_a and clear_b, count=0, go to ENTER_A; the key is consumed and not shifted.
REQ-012 CLEAR in any state: pulse clear_a and clear_b, count=0, op_code kept, go to ENTER_A; in CALC this aborts, and a later alu_done is ignored.
REQ-013 alu_done outside CALC SHALL be ignored.
REQ-014 Reserved key codes SHALL be ignored in every state.
REQ-015 key_valid and alu_done in the same CALC cycle: CLEAR wins; otherwise alu_done is taken and the key is dropped.
REQ-016 At most one of shift_a, shift_b, clear_* groups and alu_start SHALL pulse per cycle.
REQ-017 The digit counter SHALL be $clog2(DIGITS+1) bits wide, compare unsigned, and never wrap.

Reset
REQ-018 rst SHALL be synchronous and active-high.
REQ-019 While rst=1, the block SHALL be in ENTER_A with count=0, op_code=00, and all pulse and level outputs 0 (digits_full=0, show_result=0).
REQ-020 rst asserted mid-operation (including in CALC) SHALL override all other inputs that cycle.
REQ-021 The parent SHALL drive the operand registers' own reset from the same rst.

Structure
REQ-022 Package calc_pkg SHALL hold the state enum, the key-code localparams (KEY_ENTER, KEY_CLEAR, KEY_ADD..KEY_OR), and the op_code enum.
REQ-023 calc_entry_ctrl SHALL be a single module with no sub-modules.
REQ-024 The two operand shift registers and the ALU are instantiated in the parent and connected through shift_*/clear_*/digit_out.

Verification
REQ-025 Keys 1,2,3,4,5,ENTER -> four shift_a pulses with digit_out 1,2,3,4; digit 5 is ignored, digits_full=1; state goes to ENTER_OP.
REQ-026 A=0xA, ENTER, SUB, B=0x3, ENTER -> op_code=01, one alu_start pulse; alu_done 5 cycles later -> show_result=1.
REQ-027 ENTER with no digits in ENTER_A and in ENTER_B -> state unchanged, no alu_start.
REQ-028 CLEAR in CALC, then alu_done -> clear_a and clear_b pulse once, state ENTER_A, show_result stays 0.
REQ-029 rst for 1 cycle while in ENTER_B with count=2 -> next cycle ENTER_A, all outputs 0, op_code=00.
REQ-030 Digit key in SHOW -> clear pulses, ENTER_A, no shift_a that cycle or the next.
